alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 145 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Two-entry issue buffer sitting in front of a classic AND/OR/ADD/LESS ALU.
//   Opcodes are decoded into ALU control bits when they are accepted, so each
//   buffer entry holds both operands plus the decoded controls.  Everything
//   presented downstream comes from the head-entry registers.
//
// Ports
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   InValid/InReady         upstream handshake
//   InOp, InA, InB          opcode and operands offered upstream
//   Flush                   synchronous discard of all buffered entries
//   OutValid/OutReady       downstream (ALU) handshake
//   OutA, OutB              operands of the head entry
//   AInvert, BInvert,
//   CarryIn, Operation      decoded ALU controls of the head entry
//   IllegalOp               sticky flag, set when an illegal opcode is taken
//   IssueCount              wrapping count of completed output transfers
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       InOp,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             AInvert,
  output logic             BInvert,
  output logic             CarryIn,
  output logic [1:0]       Operation,
  output logic             IllegalOp,
  output logic [15:0]      IssueCount
);

  localparam logic [1:0] LP_FULL = 2'(DEPTH);

  // Slot 0 is always the head; slot 1 only holds data when two are buffered.
  logic [WIDTH-1:0] r_a0, r_b0, r_a1, r_b1;
  logic [4:0]       r_ctrl0, r_ctrl1;
  logic [1:0]       r_count;
  logic [15:0]      r_issue;
  logic             r_illegal;

  logic [4:0]       w_ctrl;
  logic             w_legal;
  logic             w_take;
  logic             w_push;
  logic             w_pop;
  logic             w_toSlot1;

  // Controls packed as {AInvert, BInvert, CarryIn, Operation[1:0]}.
  always_comb begin
    w_legal = 1'b1;
    w_ctrl  = 5'b00000;
    case (InOp)
      3'b000:  w_ctrl = 5'b00000;
      3'b001:  w_ctrl = 5'b00001;
      3'b010:  w_ctrl = 5'b00010;
      3'b011:  w_ctrl = 5'b01110;
      3'b100:  w_ctrl = 5'b01111;
      3'b101:  w_ctrl = 5'b11000;
      default: w_legal = 1'b0;
    endcase
  end

  // InReady depends on registered occupancy only, never on OutReady.
  assign InReady  = (r_count < LP_FULL);
  assign OutValid = (r_count != 2'd0);

  assign w_take = InValid && InReady && !Flush;
  assign w_push = w_take && w_legal;
  assign w_pop  = OutValid && OutReady && !Flush;

  // A push lands behind the head unless the head leaves on the same edge,
  // in which case the new entry becomes the head directly.
  assign w_toSlot1 = (r_count == 2'd1) && !w_pop;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= 2'd0;
      r_a0    <= '0;
      r_b0    <= '0;
      r_ctrl0 <= '0;
      r_a1    <= '0;
      r_b1    <= '0;
      r_ctrl1 <= '0;
    end else if (Flush) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_a0    <= r_a1;
        r_b0    <= r_b1;
        r_ctrl0 <= r_ctrl1;
      end
      if (w_push) begin
        if (w_toSlot1) begin
          r_a1    <= InA;
          r_b1    <= InB;
          r_ctrl1 <= w_ctrl;
        end else begin
          r_a0    <= InA;
          r_b0    <= InB;
          r_ctrl0 <= w_ctrl;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_issue <= 16'd0;
    end else if (w_pop) begin
      r_issue <= r_issue + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_illegal <= 1'b0;
    end else if (w_take && !w_legal) begin
      r_illegal <= 1'b1;
    end
  end

  // Stale slot contents stay hidden while the buffer is empty.
  assign OutA       = OutValid ? r_a0 : '0;
  assign OutB       = OutValid ? r_b0 : '0;
  assign AInvert    = OutValid & r_ctrl0[4];
  assign BInvert    = OutValid & r_ctrl0[3];
  assign CarryIn    = OutValid & r_ctrl0[2];
  assign Operation  = OutValid ? r_ctrl0[1:0] : 2'b00;
  assign IllegalOp  = r_illegal;
  assign IssueCount = r_issue;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Self-checking bench for alu_issue_stage.  A queue-based reference model
//   tracks buffered operations; expected controls come from the opcode table.
//   Directed scenarios cover latency, back-pressure, illegal opcodes, flush,
//   asynchronous reset and counter wrap, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int W = 24;

  logic          Clock;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [2:0]    InOp;
  logic [W-1:0]  InA;
  logic [W-1:0]  InB;
  logic          Flush;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  OutA;
  logic [W-1:0]  OutB;
  logic          AInvert;
  logic          BInvert;
  logic          CarryIn;
  logic [1:0]    Operation;
  logic          IllegalOp;
  logic [15:0]   IssueCount;

  alu_issue_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InOp       (InOp),
    .InA        (InA),
    .InB        (InB),
    .Flush      (Flush),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutA       (OutA),
    .OutB       (OutB),
    .AInvert    (AInvert),
    .BInvert    (BInvert),
    .CarryIn    (CarryIn),
    .Operation  (Operation),
    .IllegalOp  (IllegalOp),
    .IssueCount (IssueCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Opcode table: {AInvert, BInvert, CarryIn, Operation} for AND OR ADD SUB SLT NOR.
  logic [4:0] decTable [0:5];
  initial begin
    decTable[0] = 5'b00000;
    decTable[1] = 5'b00001;
    decTable[2] = 5'b00010;
    decTable[3] = 5'b01110;
    decTable[4] = 5'b01111;
    decTable[5] = 5'b11000;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           op;
  } entry_t;

  entry_t      refQ[$];
  logic [15:0] refIssue;
  logic        refIllegal;
  bit          doCheck;
  int          assertCount;
  int          failCount;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current state.
  task automatic checkAll();
    logic [4:0]   expCtrl;
    logic [W-1:0] expA;
    logic [W-1:0] expB;
    expCtrl = 5'b00000;
    expA    = '0;
    expB    = '0;
    if (refQ.size() != 0) begin
      expCtrl = decTable[refQ[0].op];
      expA    = refQ[0].a;
      expB    = refQ[0].b;
    end
    checkOutput("InReady",    32'(InReady),    32'(refQ.size() < 2));
    checkOutput("OutValid",   32'(OutValid),   32'(refQ.size() != 0));
    checkOutput("OutA",       32'(OutA),       32'(expA));
    checkOutput("OutB",       32'(OutB),       32'(expB));
    checkOutput("controls",   32'({AInvert, BInvert, CarryIn, Operation}), 32'(expCtrl));
    checkOutput("IllegalOp",  32'(IllegalOp),  32'(refIllegal));
    checkOutput("IssueCount", 32'(IssueCount), 32'(refIssue));
  endtask

  // Drive one cycle from a negedge, check pre-edge outputs, advance the model.
  task automatic applyStimulus(input logic inV, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic fl, input logic ordy);
    bit     rdy;
    bit     vld;
    entry_t e;
    InValid  = inV;
    InOp     = op;
    InA      = a;
    InB      = b;
    Flush    = fl;
    OutReady = ordy;
    #1;
    if (doCheck) checkAll();
    rdy = (refQ.size() < 2);
    vld = (refQ.size() != 0);
    if (fl) begin
      refQ.delete();
    end else begin
      if (vld && ordy) begin
        refQ.delete(0);
        refIssue = refIssue + 16'd1;
      end
      if (inV && rdy) begin
        if (int'(op) < 6) begin
          e.a  = a;
          e.b  = b;
          e.op = int'(op);
          refQ.push_back(e);
        end else begin
          refIllegal = 1'b1;
        end
      end
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Pulse reset between clock edges and check the immediate effect.
  task automatic midReset();
    InValid = 1'b0;
    Flush   = 1'b0;
    #2;
    Reset = 1'b0;
    refQ.delete();
    refIssue   = 16'd0;
    refIllegal = 1'b0;
    #1;
    checkAll();
    #1;
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  initial begin
    int iter;
    assertCount = 0;
    failCount   = 0;
    doCheck     = 1'b1;
    refIssue    = 16'd0;
    refIllegal  = 1'b0;
    Reset       = 1'b0;
    InValid     = 1'b0;
    InOp        = 3'b000;
    InA         = '0;
    InB         = '0;
    Flush       = 1'b0;
    OutReady    = 1'b0;

    repeat (2) @(negedge Clock);
    #1;
    checkAll();
    @(negedge Clock);
    Reset = 1'b1;

    // SUB 5 - 3 accepted on first edge after reset, presented next cycle.
    applyStimulus(1'b1, 3'b011, 24'h000005, 24'h000003, 1'b0, 1'b1);
    checkOutput("sub valid", 32'(OutValid), 32'd1);
    checkOutput("sub ctrl",  32'({AInvert, BInvert, CarryIn, Operation}), 32'h0E);
    checkOutput("sub A",     32'(OutA), 32'h5);
    checkOutput("sub B",     32'(OutB), 32'h3);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);
    checkOutput("sub count", 32'(IssueCount), 32'd1);

    // Back-pressure: NOR then SLT with the ALU stalled.
    applyStimulus(1'b1, 3'b101, rnd(), rnd(), 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b100, rnd(), rnd(), 1'b0, 1'b0);
    checkOutput("full ready", 32'(InReady), 32'd0);
    checkOutput("nor ctrl",   32'({AInvert, BInvert, CarryIn, Operation}), 32'h18);
    applyStimulus(1'b1, 3'b000, rnd(), rnd(), 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);
    checkOutput("slt ctrl",   32'({AInvert, BInvert, CarryIn, Operation}), 32'h0F);
    checkOutput("ready after pop", 32'(InReady), 32'd1);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);

    // Illegal opcode is consumed but never enqueued.
    applyStimulus(1'b1, 3'b111, rnd(), rnd(), 1'b0, 1'b1);
    checkOutput("illegal flag",  32'(IllegalOp), 32'd1);
    checkOutput("illegal valid", 32'(OutValid),  32'd0);
    applyStimulus(1'b1, 3'b110, rnd(), rnd(), 1'b0, 1'b1);

    // Flush overrides same-edge push and pop at full occupancy.
    applyStimulus(1'b1, 3'b010, rnd(), rnd(), 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b001, rnd(), rnd(), 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, rnd(), rnd(), 1'b1, 1'b1);
    checkOutput("flush valid", 32'(OutValid), 32'd0);
    checkOutput("flush count", 32'(IssueCount), 32'(refIssue));
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset with one entry buffered.
    applyStimulus(1'b1, 3'b010, rnd(), rnd(), 1'b0, 1'b0);
    midReset();
    applyStimulus(1'b1, 3'b001, rnd(), rnd(), 1'b0, 1'b0);
    checkOutput("post-reset accept", 32'(OutValid), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) midReset();
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd(), rnd(),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
    end

    // Drive IssueCount to 0xFFFF, then wrap it with one more pop.
    midReset();
    doCheck = 1'b0;
    iter = 0;
    while (refIssue != 16'hFFFF && iter < 70000) begin
      applyStimulus(1'b1, 3'b010, rnd(), rnd(), 1'b0, 1'b1);
      iter++;
    end
    doCheck = 1'b1;
    checkOutput("wrap bound", 32'(iter < 70000), 32'd1);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
    checkOutput("count max", 32'(IssueCount), 32'hFFFF);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b1);
    checkOutput("count wrap", 32'(IssueCount), 32'h0000);
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
